// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, frame constants and parity helper
package uart_pkg;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_FRAME_BITS = 11;
  localparam logic [3:0] BIT_START = 4'd0;
  localparam logic [3:0] BIT_PARITY = 4'd9;
  localparam logic [3:0] BIT_STOP = 4'd10;
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line and received-byte signals of the UART receiver
interface uart_receiver_if;
  logic rx_in;
  logic [7:0] data_out;
  logic rx_valid;
  logic parity_err;
  logic frame_err;
  logic rx_busy;
  modport master (input rx_in, output data_out, rx_valid, parity_err, frame_err, rx_busy);
  modport slave (output rx_in, input data_out, rx_valid, parity_err, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep synchroniser for the serial line, resets to idle-high
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_ff
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk)
      ff <= reset ? '1 : STAGES'({ff, d});
    assign q = ff[STAGES-1];
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: mid-bit sampling UART receiver (start, 8 data LSB-first, parity, stop)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD = 0
) (
  input logic clk,
  input logic reset,
  uart_receiver_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  rx_state_t state, state_n;
  logic rx_s, tick, par, par_n, valid_n, perr_n, ferr_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0] idx, idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n, data_n;
  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .d(bus.rx_in), .q(rx_s));
  assign cnt_inc = cnt == LAST ? '0 : cnt + 1'b1;
  assign tick = cnt == MID;
  assign bus.rx_busy = state != RX_IDLE;
  // with MID==0 the detection cycle is itself the start-bit sample
  always_comb begin
    state_n = state;
    cnt_n = cnt_inc;
    idx_n = idx;
    shift_n = shift;
    par_n = par;
    data_n = bus.data_out;
    valid_n = 1'b0;
    perr_n = bus.parity_err;
    ferr_n = bus.frame_err;
    case (state)
      RX_IDLE: begin
        cnt_n = rx_s ? '0 : cnt_inc;
        idx_n = (!rx_s && MID == '0) ? BIT_START + 4'd1 : BIT_START;
        state_n = rx_s ? RX_IDLE : (MID == '0 ? RX_DATA : RX_START);
      end
      RX_START: if (tick) begin
        state_n = rx_s ? RX_IDLE : RX_DATA;
        cnt_n = rx_s ? '0 : cnt_inc;
        idx_n = idx + 4'd1;
      end
      RX_DATA: if (tick) begin
        shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
        idx_n = idx + 4'd1;
        state_n = idx == BIT_PARITY - 4'd1 ? RX_PARITY : RX_DATA;
      end
      RX_PARITY: if (tick) begin
        par_n = rx_s;
        idx_n = BIT_STOP;
        state_n = RX_STOP;
      end
      RX_STOP: if (tick) begin
        valid_n = 1'b1;
        data_n = shift;
        perr_n = par != parity_bit(shift, 1'(PARITY_ODD));
        ferr_n = !rx_s;
        cnt_n = '0;
        idx_n = BIT_START;
        state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: begin
        cnt_n = '0;
        state_n = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      default: state_n = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_IDLE;
      cnt <= '0;
      idx <= BIT_START;
      shift <= '0;
      par <= 1'b0;
      bus.data_out <= '0;
      bus.rx_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      par <= par_n;
      bus.data_out <= data_n;
      bus.rx_valid <= valid_n;
      bus.parity_err <= perr_n;
      bus.frame_err <= ferr_n;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table vectors, corner sequences and randomized frames against a frame-level model
module tb_uart_receiver;
  import uart_pkg::*;
  localparam int P = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #(P/2) clk = ~clk;
  uart_receiver_if b1();
  uart_receiver_if b16();
  uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(2), .PARITY_ODD(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  uart_receiver #(.CLKS_PER_BIT(16), .SYNC_STAGES(2), .PARITY_ODD(0)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  typedef struct {longint t; logic [7:0] d; logic pe; logic fe;} ev_t;
  typedef struct {logic [7:0] d; logic par; logic stop; logic [7:0] ed; logic epe; logic efe;} vec_t;
  ev_t obs1[$], obs16[$], exp1[$], exp16[$];
  vec_t vec[9];
  int checks = 0;
  int failures = 0;
  always @(negedge clk) begin
    if (b1.rx_valid === 1'b1) obs1.push_back('{longint'($time), b1.data_out, b1.parity_err, b1.frame_err});
    if (b16.rx_valid === 1'b1) obs16.push_back('{longint'($time), b16.data_out, b16.parity_err, b16.frame_err});
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic drive(input int w, input logic v);
    if (w == 1) b1.rx_in = v;
    else b16.rx_in = v;
  endtask
  task automatic line(input int w, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      drive(w, v);
      @(negedge clk);
    end
  endtask
  task automatic send(input int w, input int c, input logic [7:0] d, input logic par, input logic stop,
                      input bit noise, output longint ts);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    ts = longint'($time);
    for (int k = 0; k < UART_FRAME_BITS; k++)
      for (int j = 0; j < c; j++) begin
        drive(w, (noise && k >= 1 && k <= 9 && j != (c - 1) / 2) ? 1'($urandom_range(1)) : f[k]);
        @(negedge clk);
      end
  endtask
  task automatic rand_run(input int w, input int c, input int nf, input bit noise);
    logic [7:0] d;
    logic par, stop;
    longint ts;
    int gap, lat;
    ev_t e;
    lat = 2 + 10 * c + (c - 1) / 2 + 1;
    for (int n = 0; n < nf; n++) begin
      d = 8'($urandom);
      par = ($urandom_range(3) == 0) ? ~^d : ^d;
      stop = $urandom_range(9) != 0;
      gap = $urandom_range(2) + (stop ? 0 : 1);
      send(w, c, d, par, stop, noise, ts);
      e = '{ts + longint'(lat * P), d, par != ^d, !stop};
      if (w == 1) exp1.push_back(e);
      else exp16.push_back(e);
      line(w, 1'b1, gap * c);
    end
    line(w, 1'b1, lat + 2 * c);
  endtask
  task automatic compare_q(input string tag, input ev_t e[$], input ev_t o[$]);
    check({tag, "_count"}, o.size(), e.size());
    for (int i = 0; i < e.size() && i < o.size(); i++) begin
      check($sformatf("%s%0d_time", tag, i), o[i].t, e[i].t);
      check($sformatf("%s%0d_data", tag, i), o[i].d, e[i].d);
      check($sformatf("%s%0d_perr", tag, i), o[i].pe, e[i].pe);
      check($sformatf("%s%0d_ferr", tag, i), o[i].fe, e[i].fe);
    end
  endtask
  initial begin
    longint ts, ts2;
    vec[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vec[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vec[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vec[3] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vec[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vec[5] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
    vec[6] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    vec[7] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1};
    vec[8] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    b1.rx_in = 1'b1;
    b16.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", b1.data_out, 8'h00);
    check("rst_valid", b1.rx_valid, 1'b0);
    check("rst_perr", b1.parity_err, 1'b0);
    check("rst_ferr", b1.frame_err, 1'b0);
    check("rst_busy", b1.rx_busy, 1'b0);
    check("rst_busy16", b16.rx_busy, 1'b0);
    reset = 1'b0;
    line(1, 1'b1, 4);
    foreach (vec[i]) begin
      obs1.delete();
      send(1, 1, vec[i].d, vec[i].par, vec[i].stop, 1'b0, ts);
      line(1, 1'b1, 16);
      check($sformatf("vec%0d_count", i), obs1.size(), 1);
      if (obs1.size() >= 1) begin
        check($sformatf("vec%0d_data", i), obs1[0].d, vec[i].ed);
        check($sformatf("vec%0d_perr", i), obs1[0].pe, vec[i].epe);
        check($sformatf("vec%0d_ferr", i), obs1[0].fe, vec[i].efe);
        check($sformatf("vec%0d_latency", i), (obs1[0].t - ts) / P, 13);
      end
    end
    obs1.delete();
    send(1, 1, 8'h81, 1'b0, 1'b0, 1'b0, ts);
    line(1, 1'b0, 20);
    check("brk_busy_low", b1.rx_busy, 1'b1);
    line(1, 1'b1, 6);
    check("brk_busy_high", b1.rx_busy, 1'b0);
    line(1, 1'b1, 10);
    check("brk_count", obs1.size(), 1);
    if (obs1.size() >= 1) begin
      check("brk_data", obs1[0].d, 8'h81);
      check("brk_ferr", obs1[0].fe, 1'b1);
      check("brk_perr", obs1[0].pe, 1'b0);
    end
    obs1.delete();
    send(1, 1, 8'h00, 1'b0, 1'b1, 1'b0, ts);
    send(1, 1, 8'hFF, 1'b0, 1'b1, 1'b0, ts2);
    line(1, 1'b1, 16);
    check("b2b_count", obs1.size(), 2);
    if (obs1.size() >= 2) begin
      check("b2b_data0", obs1[0].d, 8'h00);
      check("b2b_data1", obs1[1].d, 8'hFF);
      check("b2b_gap", (obs1[1].t - obs1[0].t) / P, 11);
      check("b2b_err", {obs1[0].pe, obs1[0].fe, obs1[1].pe, obs1[1].fe}, 4'b0000);
    end
    obs1.delete();
    begin
      logic [10:0] f;
      f = {1'b1, 1'b0, 8'h3C, 1'b0};
      for (int k = 0; k < 7; k++) line(1, f[k], 1);
    end
    reset = 1'b1;
    b1.rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_data", b1.data_out, 8'h00);
    check("mid_rst_valid", b1.rx_valid, 1'b0);
    check("mid_rst_perr", b1.parity_err, 1'b0);
    check("mid_rst_ferr", b1.frame_err, 1'b0);
    check("mid_rst_busy", b1.rx_busy, 1'b0);
    reset = 1'b0;
    line(1, 1'b1, 20);
    check("mid_rst_count", obs1.size(), 0);
    send(1, 1, 8'h5A, 1'b0, 1'b1, 1'b0, ts);
    line(1, 1'b1, 16);
    check("post_rst_count", obs1.size(), 1);
    if (obs1.size() >= 1) begin
      check("post_rst_data", obs1[0].d, 8'h5A);
      check("post_rst_err", {obs1[0].pe, obs1[0].fe}, 2'b00);
    end
    obs16.delete();
    line(16, 1'b0, 3);
    line(16, 1'b1, 2);
    check("glitch_busy", b16.rx_busy, 1'b1);
    line(16, 1'b1, 10);
    check("glitch_idle", b16.rx_busy, 1'b0);
    line(16, 1'b1, 15);
    check("glitch_count", obs16.size(), 0);
    obs1.delete();
    exp1.delete();
    rand_run(1, 1, 40, 1'b0);
    compare_q("rnd1_", exp1, obs1);
    obs16.delete();
    exp16.delete();
    rand_run(16, 16, 12, 1'b1);
    compare_q("rnd16_", exp16, obs16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
